// File: rtl/zc_freq_det_pkg.sv
// Shared types and helpers for the zero-crossing frequency detector.
package zc_freq_det_pkg;

  typedef enum logic [2:0] {SEARCH, ARM0, HIGH0, ARMED, HIGH} state_t;

  // Returns {high, low}; both clear means the sample lies inside the hysteresis band.
  function automatic logic [1:0] thr_cmp(input longint sample, input longint hyst);
    return {sample >= hyst, sample <= -hyst};
  endfunction

endpackage

// File: rtl/period_to_freq.sv
// Registered conversion of a measured period (clk cycles) into an NCO frequency code.
module period_to_freq #(
  parameter int unsigned PERIOD_WIDTH = 20,
  parameter int unsigned PHI_WIDTH    = 8,
  parameter int unsigned FREQ_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic [FREQ_WIDTH-1:0]   freq,
  output logic                    out_vld
);

  logic [PERIOD_WIDTH-1:0] step;
  logic [PERIOD_WIDTH-1:0] step_m1;
  logic [FREQ_WIDTH-1:0]   freq_d;

  always_comb begin
    step    = period >> PHI_WIDTH;
    step_m1 = step - PERIOD_WIDTH'(1);
    freq_d  = '1;
    if (step == '0) begin
      freq_d = '1;
    end else if (|(step_m1 >> FREQ_WIDTH)) begin
      // Slower than the NCO can go: clamp to the lowest code.
      freq_d = '0;
    end else begin
      freq_d = ~FREQ_WIDTH'(step_m1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq    <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        freq <= freq_d;
      end
    end
  end

endmodule

// File: rtl/zc_freq_det.sv
// Zero-crossing pitch detector: times rising hysteresis crossings and emits an NCO freq code.
module zc_freq_det
  import zc_freq_det_pkg::*;
#(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned FREQ_WIDTH   = 8,
  parameter int unsigned PERIOD_WIDTH = 20,
  parameter int unsigned HYST         = 1024,
  parameter int unsigned MAX_PERIOD   = (32'd1 << PERIOD_WIDTH) - 32'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_vld,
  input  logic signed [WIDTH-1:0] in_wav,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [FREQ_WIDTH-1:0]   freq,
  output logic                    out_vld,
  output logic                    locked
);

  localparam int unsigned PHI_WIDTH = $clog2(DEPTH);

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic                    meas;
  logic [1:0]              lvl;
  logic                    is_low;
  logic                    is_high;
  logic                    counting;
  logic                    timeout;

  assign lvl      = thr_cmp(longint'(in_wav), longint'(HYST));
  assign is_low   = lvl[0];
  assign is_high  = lvl[1];
  assign counting = state inside {HIGH0, ARMED, HIGH};
  assign timeout  = counting && (cnt == PERIOD_WIDTH'(MAX_PERIOD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      cnt    <= '0;
      period <= '0;
      meas   <= 1'b0;
      locked <= 1'b0;
    end else begin
      meas <= 1'b0;
      // Timeout outranks any crossing seen on the same cycle.
      if (!en || timeout) begin
        state  <= SEARCH;
        cnt    <= '0;
        locked <= 1'b0;
      end else begin
        if (counting) begin
          cnt <= cnt + PERIOD_WIDTH'(1);
        end
        if (meas) begin
          locked <= 1'b1;
        end
        if (in_vld) begin
          unique case (state)
            SEARCH: if (is_low) state <= ARM0;
            ARM0: begin
              if (is_high) begin
                state <= HIGH0;
                cnt   <= '0;
              end
            end
            HIGH0: if (is_low) state <= ARMED;
            ARMED: begin
              if (is_high) begin
                state  <= HIGH;
                cnt    <= '0;
                period <= cnt + PERIOD_WIDTH'(1);
                meas   <= 1'b1;
              end
            end
            HIGH: if (is_low) state <= ARMED;
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

  period_to_freq #(
    .PERIOD_WIDTH(PERIOD_WIDTH),
    .PHI_WIDTH   (PHI_WIDTH),
    .FREQ_WIDTH  (FREQ_WIDTH)
  ) u_p2f (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (meas),
    .period (period),
    .freq   (freq),
    .out_vld(out_vld)
  );

endmodule

// File: tb/tb_zc_freq_det.sv
// Randomized bench for zc_freq_det: a default instance and a small-depth/short-timeout instance.
module tb_zc_freq_det;

  localparam longint HYST   = 1024;
  localparam longint MAX_A  = (64'd1 << 20) - 1;
  localparam longint MAX_B  = (64'd1 << 13) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               in_vld;
  logic signed [23:0] in_wav;

  logic [19:0] period_a;
  logic [7:0]  freq_a;
  logic        vld_a;
  logic        lock_a;
  logic [12:0] period_b;
  logic [7:0]  freq_b;
  logic        vld_b;
  logic        lock_b;

  always #5 clk = ~clk;

  zc_freq_det dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .in_vld (in_vld),
    .in_wav (in_wav),
    .period (period_a),
    .freq   (freq_a),
    .out_vld(vld_a),
    .locked (lock_a)
  );

  zc_freq_det #(
    .DEPTH       (16),
    .PERIOD_WIDTH(13)
  ) dut_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .in_vld (in_vld),
    .in_wav (in_wav),
    .period (period_b),
    .freq   (freq_b),
    .out_vld(vld_b),
    .locked (lock_b)
  );

  // Reference: remembers whether a low was seen since the last rising event and when that
  // event happened; a period is the cycle distance between two events without a timeout.
  typedef struct packed {
    bit     seen_low;
    bit     have_ref;
    longint last_ev;
    bit     pend;
    longint pend_per;
    longint period;
    longint freq;
    bit     vld;
    bit     locked;
  } mdl_t;

  mdl_t   ma, mb;
  longint cyc;
  int     n_chk, n_bad;

  function automatic longint ref_freq(input longint per, input longint depth);
    longint step;
    step = per / depth;
    if (step == 0) return 255;
    if (step > 256) return 0;
    return 256 - step;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input longint t, input bit en_s,
                                    input bit vld_s, input longint wav, input longint depth,
                                    input longint maxp);
    mdl_t r;
    r = m;
    r.vld = m.pend;
    if (m.pend) begin
      r.freq   = ref_freq(m.pend_per, depth);
      r.locked = 1'b1;
    end
    r.pend = 1'b0;
    if (!en_s || (m.have_ref && (t - m.last_ev - 1 == maxp))) begin
      r.seen_low = 1'b0;
      r.have_ref = 1'b0;
      r.locked   = 1'b0;
    end else if (vld_s) begin
      if (wav <= -HYST) begin
        r.seen_low = 1'b1;
      end else if (wav >= HYST && m.seen_low) begin
        if (m.have_ref) begin
          r.period   = t - m.last_ev;
          r.pend     = 1'b1;
          r.pend_per = t - m.last_ev;
        end
        r.have_ref = 1'b1;
        r.last_ev  = t;
        r.seen_low = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      ma = mdl_step(ma, cyc, en, in_vld, longint'(in_wav), 256, MAX_A);
      mb = mdl_step(mb, cyc, en, in_vld, longint'(in_wav), 16, MAX_B);
    end
    #1;
    check("a_period", 64'(period_a), ma.period);
    check("a_freq", 64'(freq_a), ma.freq);
    check("a_vld", 64'(vld_a), 64'(ma.vld));
    check("a_locked", 64'(lock_a), 64'(ma.locked));
    check("b_period", 64'(period_b), mb.period);
    check("b_freq", 64'(freq_b), mb.freq);
    check("b_vld", 64'(vld_b), 64'(mb.vld));
    check("b_locked", 64'(lock_b), 64'(mb.locked));
  endtask

  task automatic drive(input longint wav, input bit v);
    in_wav = 24'(wav);
    in_vld = v;
    tick();
  endtask

  task automatic square(input int hi_len, input int lo_len, input int n, input bit sparse);
    longint amp;
    for (int p = 0; p < n; p++) begin
      amp = longint'($urandom_range(4096, 4194304));
      for (int i = 0; i < hi_len; i++) drive(amp, sparse ? ($urandom_range(0, 3) != 0) : 1'b1);
      for (int i = 0; i < lo_len; i++) drive(-amp, sparse ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pa"}, 64'(period_a), 0);
    check({tag, "_fa"}, 64'(freq_a), 0);
    check({tag, "_va"}, 64'(vld_a), 0);
    check({tag, "_la"}, 64'(lock_a), 0);
    check({tag, "_pb"}, 64'(period_b), 0);
    check({tag, "_lb"}, 64'(lock_b), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     nv;
    int     hold;
    longint amp;
    n_chk  = 0;
    n_bad  = 0;
    cyc    = 0;
    ma     = '0;
    mb     = '0;
    rst_n  = 1'b0;
    en     = 1'b1;
    in_vld = 1'b0;
    in_wav = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;

    // 1024-cycle square wave
    square(512, 512, 5, 1'b0);
    check("sq_period", 64'(period_a), 1024);
    check("sq_freq", 64'(freq_a), 8'hFC);
    check("sq_locked", 64'(lock_a), 1);
    check("sq_freq_s", 64'(freq_b), 192);

    // Irregular strobe and asymmetric duty
    square(600, 424, 4, 1'b1);

    // Sine with a 512-cycle period
    amp = longint'($urandom_range(8192, 4000000));
    for (int i = 0; i < 6 * 512; i++) begin
      drive(longint'($rtoi(real'(amp) * $sin(6.283185307179586 * real'(i) / 512.0))), 1'b1);
    end
    check("sine_per_ok", 64'((period_a >= 20'd511) && (period_a <= 20'd513)), 1);
    check("sine_freq", 64'(freq_a), 8'hFE);

    // In-band noise after lock: no updates; short-timeout instance drops lock
    square(512, 512, 3, 1'b0);
    nv = 0;
    for (int i = 0; i < 9000; i++) begin
      drive(longint'($urandom_range(0, 2046)) - 1023, 1'b1);
      nv += int'(vld_a) + int'(vld_b);
    end
    check("noise_vld", 64'(nv), 0);
    check("noise_lock_a", 64'(lock_a), 1);
    check("noise_lock_b", 64'(lock_b), 0);
    check("noise_hold_pb", 64'(period_b), 1024);
    check("noise_hold_fb", 64'(freq_b), 192);

    // Clamp ends
    square(50, 50, 6, 1'b0);
    check("clamp_hi", 64'(freq_a), 8'hFF);
    square(2500, 2500, 3, 1'b0);
    check("clamp_lo", 64'(freq_b), 8'h00);
    check("clamp_lo_a", 64'(freq_a), 237);

    // Async reset mid-period
    square(512, 512, 2, 1'b0);
    for (int i = 0; i < int'($urandom_range(50, 450)); i++) drive(4096, 1'b1);
    #3;
    rst_n = 1'b0;
    ma    = '0;
    mb    = '0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) drive(-4096, 1'b1);
    for (int i = 0; i < 512; i++) drive(4096, 1'b1);
    check("relock_one_edge", 64'(lock_a), 0);
    for (int i = 0; i < 512; i++) drive(-4096, 1'b1);
    for (int i = 0; i < 10; i++) drive(4096, 1'b1);
    check("relock_two_edges", 64'(lock_a), 1);
    for (int i = 0; i < 502; i++) drive(4096, 1'b1);

    // Disable mid-period
    square(512, 512, 2, 1'b0);
    for (int i = 0; i < int'($urandom_range(50, 450)); i++) drive(4096, 1'b1);
    en = 1'b0;
    drive(4096, 1'b1);
    check("dis_lock", 64'(lock_a), 0);
    check("dis_freq_hold", 64'(freq_a), 8'hFC);
    hold = int'($urandom_range(20, 80));
    for (int i = 0; i < hold; i++) drive(-4096, 1'b1);
    en = 1'b1;
    square(512, 512, 3, 1'b0);
    check("reen_lock", 64'(lock_a), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
